// File: rtl/accum_pkg.sv
// Shared types and width helpers for the accumulator zone responder.
// IDLE: accepting commands | ACC_RD: RMW bank read in flight | ACC_WB: sum written back
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_RD = 2'd1,
        ACC_WB = 2'd2
    } acc_state_t;

    function automatic int bus_width(input int num_banks, input int data_width);
        return num_banks * data_width;
    endfunction

    function automatic int lane_lsb(input int lane, input int data_width);
        return lane * data_width;
    endfunction

endpackage

// File: rtl/accum_bank_ram.sv
// Single-port bank RAM, synchronous read with one cycle of latency.
module accum_bank_ram #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/accum_zone_responder.sv
// Zone responder: plain/accumulate writes and masked reads over NUM_BANKS bank RAMs.
// Commands for another zone are handshaked, then dropped with a zone_err pulse.
module accum_zone_responder
    import accum_pkg::*;
#(
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64,
    parameter int ZONE_WIDTH = 2,
    parameter int ZONE_ID    = 0
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [ADDR_WIDTH-1:0]           wr_addr,
    input  logic [NUM_BANKS-1:0]            wr_mask,
    input  logic [ZONE_WIDTH-1:0]           wr_zone_id,
    input  logic                            accum_en,
    input  logic                            wvalid,
    output logic                            wready,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] wdata,
    input  logic                            rd_valid,
    output logic                            rd_ready,
    input  logic [ADDR_WIDTH-1:0]           rd_addr,
    input  logic [NUM_BANKS-1:0]            rd_mask,
    input  logic [ZONE_WIDTH-1:0]           rd_zone_id,
    output logic                            rvalid,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] rdata,
    output logic                            zone_err
);

    localparam int                    BUS_WIDTH = bus_width(NUM_BANKS, DATA_WIDTH);
    localparam logic [ZONE_WIDTH-1:0] ZONE_SEL  = ZONE_WIDTH'(ZONE_ID);

    acc_state_t state, state_nxt;

    logic                  idle;
    logic                  wr_both;
    logic                  wr_hs;
    logic                  rd_hs;
    logic                  wr_zone_ok;
    logic                  rd_zone_ok;
    logic                  acc_start;
    logic                  plain_we;
    logic                  rd_go;

    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [NUM_BANKS-1:0]  cap_mask;
    logic [BUS_WIDTH-1:0]  cap_wdata;

    logic                  rvalid_q;
    logic                  zone_err_q;
    logic [NUM_BANKS-1:0]  rd_mask_q;
    logic [BUS_WIDTH-1:0]  rdata_q;

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [NUM_BANKS-1:0]  ram_we;
    logic [DATA_WIDTH-1:0] ram_din [NUM_BANKS];
    logic [DATA_WIDTH-1:0] ram_q   [NUM_BANKS];

    assign idle       = (state == IDLE);
    assign wr_both    = wr_valid & wvalid;
    assign wr_hs      = wr_both & idle;
    assign rd_hs      = rd_valid & idle & ~wr_both;
    assign wr_ready   = wr_hs;
    assign wready     = wr_hs;
    assign rd_ready   = rd_hs;

    assign wr_zone_ok = (wr_zone_id == ZONE_SEL);
    assign rd_zone_ok = (rd_zone_id == ZONE_SEL);
    assign acc_start  = wr_hs & wr_zone_ok & accum_en;
    assign plain_we   = wr_hs & wr_zone_ok & ~accum_en;
    assign rd_go      = rd_hs & rd_zone_ok;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc_start) state_nxt = ACC_RD;
            ACC_RD:  state_nxt = ACC_WB;
            ACC_WB:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cap_addr  <= '0;
            cap_mask  <= '0;
            cap_wdata <= '0;
        end else if (acc_start) begin
            cap_addr  <= wr_addr;
            cap_mask  <= wr_mask;
            cap_wdata <= wdata;
        end
    end

    // Outside IDLE the banks belong to the RMW; in IDLE a write wins the port.
    always_comb begin
        ram_addr = cap_addr;
        if (idle) begin
            ram_addr = wr_hs ? wr_addr : rd_addr;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign ram_we[b]  = (plain_we & wr_mask[b]) | ((state == ACC_WB) & cap_mask[b]);
        assign ram_din[b] = (state == ACC_WB)
                          ? ram_q[b] + cap_wdata[lane_lsb(b, DATA_WIDTH) +: DATA_WIDTH]
                          : wdata[lane_lsb(b, DATA_WIDTH) +: DATA_WIDTH];

        accum_bank_ram #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_ram (
            .clk  (clk),
            .we   (ram_we[b]),
            .addr (ram_addr),
            .din  (ram_din[b]),
            .q    (ram_q[b])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rvalid_q   <= 1'b0;
            zone_err_q <= 1'b0;
            rd_mask_q  <= '0;
            rdata_q    <= '0;
        end else begin
            rvalid_q   <= rd_go;
            zone_err_q <= (wr_hs & ~wr_zone_ok) | (rd_hs & ~rd_zone_ok);
            if (rd_go) begin
                rd_mask_q <= rd_mask;
            end
            rdata_q    <= rdata;
        end
    end

    // RAM output is live only in the rvalid cycle; rdata_q keeps it afterwards.
    always_comb begin
        rdata = rdata_q;
        if (rvalid_q) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                rdata[b*DATA_WIDTH +: DATA_WIDTH] = rd_mask_q[b] ? ram_q[b] : '0;
            end
        end
    end

    assign rvalid   = rvalid_q;
    assign zone_err = zone_err_q;

endmodule

// File: tb/tb_accum_zone_responder.sv
// Bench for accum_zone_responder: directed literal scenarios, then randomized traffic
// checked every cycle against a transaction-level memory model.
module tb_accum_zone_responder;

    localparam int NB  = 4;
    localparam int AW  = 9;
    localparam int DW  = 64;
    localparam int ZW  = 2;
    localparam int ZID = 0;
    localparam int BW  = NB * DW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          wr_valid, wr_ready, wvalid, wready, accum_en;
    logic          rd_valid, rd_ready, rvalid, zone_err;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [NB-1:0] wr_mask, rd_mask;
    logic [ZW-1:0] wr_zone_id, rd_zone_id;
    logic [BW-1:0] wdata, rdata;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    accum_zone_responder #(
        .NUM_BANKS  (NB),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ZONE_WIDTH (ZW),
        .ZONE_ID    (ZID)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_mask    (wr_mask),
        .wr_zone_id (wr_zone_id),
        .accum_en   (accum_en),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rd_mask    (rd_mask),
        .rd_zone_id (rd_zone_id),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .zone_err   (zone_err)
    );

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] lanes4(input logic [63:0] l0, input logic [63:0] l1,
                                              input logic [63:0] l2, input logic [63:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // Reference model: memory as a plain array; an accepted accumulate keeps the
    // responder busy for two cycles and lands its sum when the busy time runs out.
    logic [DW-1:0] m_mem [NB][2**AW];
    int            m_busy   = 0;
    logic [AW-1:0] p_addr   = '0;
    logic [NB-1:0] p_mask   = '0;
    logic [BW-1:0] p_data   = '0;
    logic          m_rvalid = 1'b0;
    logic          m_zerr   = 1'b0;
    logic [BW-1:0] m_rdata  = '0;

    always @(negedge clk) begin
        logic          e_wr, e_rd, n_rv, n_ze;
        logic [BW-1:0] n_rd;
        if (!rstn) begin
            m_busy   = 0;
            m_rvalid = 1'b0;
            m_zerr   = 1'b0;
            m_rdata  = '0;
        end
        e_wr = wr_valid & wvalid & (m_busy == 0);
        e_rd = rd_valid & (m_busy == 0) & ~(wr_valid & wvalid);
        check("wr_ready", BW'(wr_ready), BW'(e_wr));
        check("wready",   BW'(wready),   BW'(e_wr));
        check("rd_ready", BW'(rd_ready), BW'(e_rd));
        check("rvalid",   BW'(rvalid),   BW'(m_rvalid));
        check("zone_err", BW'(zone_err), BW'(m_zerr));
        check("rdata",    rdata,         m_rdata);
        if (rstn) begin
            n_rv = 1'b0;
            n_ze = 1'b0;
            n_rd = m_rdata;
            if (m_busy > 0) begin
                m_busy = m_busy - 1;
                if (m_busy == 0) begin
                    for (int b = 0; b < NB; b++)
                        if (p_mask[b]) m_mem[b][p_addr] = m_mem[b][p_addr] + p_data[b*DW +: DW];
                end
            end
            if (e_wr) begin
                if (wr_zone_id != ZW'(ZID)) n_ze = 1'b1;
                else if (accum_en) begin
                    p_addr = wr_addr;
                    p_mask = wr_mask;
                    p_data = wdata;
                    m_busy = 2;
                end else begin
                    for (int b = 0; b < NB; b++)
                        if (wr_mask[b]) m_mem[b][wr_addr] = wdata[b*DW +: DW];
                end
            end
            if (e_rd) begin
                if (rd_zone_id != ZW'(ZID)) n_ze = 1'b1;
                else begin
                    n_rv = 1'b1;
                    for (int b = 0; b < NB; b++)
                        n_rd[b*DW +: DW] = rd_mask[b] ? m_mem[b][rd_addr] : '0;
                end
            end
            m_rvalid = n_rv;
            m_zerr   = n_ze;
            m_rdata  = n_rd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wr_valid = 1'b0;
        wvalid   = 1'b0;
        rd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [NB-1:0] m, input logic acc,
                            input logic [BW-1:0] d, input logic [ZW-1:0] z);
        int n = 0;
        wr_valid = 1'b1; wvalid = 1'b1;
        wr_addr = a; wr_mask = m; accum_en = acc; wdata = d; wr_zone_id = z;
        #1;
        while (!wr_ready && n < 20) begin
            tick();
            n++;
        end
        if (!wr_ready) begin
            checks++; errs++;
            $display("FAIL wr_handshake_timeout: wr_ready=0 required 1");
        end
        tick();
        wr_valid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [NB-1:0] m,
                           input logic [BW-1:0] exp, input string name);
        int n = 0;
        rd_valid = 1'b1; rd_addr = a; rd_mask = m; rd_zone_id = ZW'(ZID);
        #1;
        while (!rd_ready && n < 20) begin
            tick();
            n++;
        end
        if (!rd_ready) begin
            checks++; errs++;
            $display("FAIL rd_handshake_timeout: rd_ready=0 required 1");
        end
        tick();
        rd_valid = 1'b0;
        check({name, "_rvalid"}, BW'(rvalid), BW'(1));
        check(name, rdata, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] d;
        idle_in();
        wr_addr = '0; wr_mask = '0; wr_zone_id = '0; accum_en = 1'b0; wdata = '0;
        rd_addr = '0; rd_mask = '0; rd_zone_id = '0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();

        // 1: plain write then read, latency 1
        d = lanes4(64'hA000_0000_0000_0000, 64'hA000_0000_0000_0001,
                   64'hA000_0000_0000_0002, 64'hA000_0000_0000_0003);
        do_write(9'h010, 4'hF, 1'b0, d, ZW'(ZID));
        do_read(9'h010, 4'hF, d, "t1_read");

        // 2: 0x10 then accumulate 0x20, readies held low while busy
        do_write(9'h030, 4'hF, 1'b0, lanes4(64'h10, 64'h10, 64'h10, 64'h10), ZW'(ZID));
        wr_valid = 1'b1; wvalid = 1'b1; wr_addr = 9'h030; wr_mask = 4'hF; accum_en = 1'b1;
        wdata = lanes4(64'h20, 64'h20, 64'h20, 64'h20); wr_zone_id = ZW'(ZID);
        #1;
        check("t2_accept", BW'(wr_ready), BW'(1));
        tick();
        check("t2_busy_rd_wr_ready", BW'(wr_ready), BW'(0));
        check("t2_busy_rd_wready",   BW'(wready),   BW'(0));
        tick();
        check("t2_busy_wb_wr_ready", BW'(wr_ready), BW'(0));
        idle_in();
        do_read(9'h030, 4'hF, lanes4(64'h30, 64'h30, 64'h30, 64'h30), "t2_read");

        // 3: carry out of a lane is dropped
        do_write(9'h050, 4'hF, 1'b0, lanes4(64'hFFFF_FFFF_FFFF_FFFF, 64'h5, 64'h6, 64'h7), ZW'(ZID));
        do_write(9'h050, 4'hF, 1'b1, lanes4(64'h1, 64'h1, 64'h1, 64'h1), ZW'(ZID));
        do_read(9'h050, 4'hF, lanes4(64'h0, 64'h6, 64'h7, 64'h8), "t3_wrap");

        // 4: write and read masks
        do_write(9'h040, 4'hF, 1'b0, lanes4(64'h11, 64'h22, 64'h33, 64'h44), ZW'(ZID));
        do_write(9'h040, 4'b0101, 1'b0, lanes4(64'hAA, 64'hBB, 64'hCC, 64'hDD), ZW'(ZID));
        do_read(9'h040, 4'hF, lanes4(64'hAA, 64'h22, 64'hCC, 64'h44), "t4_wmask");
        do_read(9'h040, 4'b0011, lanes4(64'hAA, 64'h22, 64'h0, 64'h0), "t4_rmask");

        // 5: simultaneous write and read to the same address
        do_write(9'h060, 4'hF, 1'b0, lanes4(64'h1, 64'h2, 64'h3, 64'h4), ZW'(ZID));
        wr_valid = 1'b1; wvalid = 1'b1; wr_addr = 9'h060; wr_mask = 4'hF; accum_en = 1'b0;
        wdata = lanes4(64'h5, 64'h6, 64'h7, 64'h8); wr_zone_id = ZW'(ZID);
        rd_valid = 1'b1; rd_addr = 9'h060; rd_mask = 4'hF; rd_zone_id = ZW'(ZID);
        #1;
        check("t5_wr_first", BW'(wr_ready), BW'(1));
        check("t5_rd_held",  BW'(rd_ready), BW'(0));
        tick();
        wr_valid = 1'b0; wvalid = 1'b0;
        #1;
        check("t5_rd_accept", BW'(rd_ready), BW'(1));
        tick();
        rd_valid = 1'b0;
        check("t5_rvalid", BW'(rvalid), BW'(1));
        check("t5_read_new", rdata, lanes4(64'h5, 64'h6, 64'h7, 64'h8));
        wvalid = 1'b1;
        #1;
        check("t5_wvalid_only_wr_ready", BW'(wr_ready), BW'(0));
        check("t5_wvalid_only_wready",   BW'(wready),   BW'(0));
        tick();
        wvalid = 1'b0; wr_valid = 1'b1;
        #1;
        check("t5_wrvalid_only_wready", BW'(wready), BW'(0));
        tick();
        idle_in();

        // 6: foreign-zone write and read, then reset during an RMW
        do_write(9'h060, 4'hF, 1'b0, lanes4(64'h9, 64'h9, 64'h9, 64'h9), ZW'(ZID + 1));
        check("t6_wr_zone_err", BW'(zone_err), BW'(1));
        do_read(9'h060, 4'hF, lanes4(64'h5, 64'h6, 64'h7, 64'h8), "t6_ram_unchanged");
        rd_valid = 1'b1; rd_addr = 9'h060; rd_mask = 4'hF; rd_zone_id = ZW'(ZID + 1);
        #1;
        check("t6_rd_accept", BW'(rd_ready), BW'(1));
        tick();
        rd_valid = 1'b0;
        check("t6_rd_zone_err", BW'(zone_err), BW'(1));
        check("t6_rd_no_rvalid", BW'(rvalid), BW'(0));
        do_write(9'h060, 4'hF, 1'b1, lanes4(64'h1, 64'h1, 64'h1, 64'h1), ZW'(ZID));
        rstn = 1'b0;
        #1;
        check("t6_rst_outputs", {BW'(wr_ready), BW'(wready)} | {BW'(rd_ready), BW'(rvalid)}
                                | {BW'(zone_err), rdata}, '0);
        check("t6_rst_rdata", rdata, '0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
        do_read(9'h060, 4'hF, lanes4(64'h5, 64'h6, 64'h7, 64'h8), "t6_rmw_abandoned");

        // randomized traffic over a small, pre-initialized address window
        for (int a = 0; a < 8; a++)
            do_write(AW'(a), 4'hF, 1'b0,
                     {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                     ZW'(ZID));
        for (int i = 0; i < 3000; i++) begin
            wr_valid   = ($urandom_range(0, 99) < 50);
            wvalid     = ($urandom_range(0, 99) < 60);
            rd_valid   = ($urandom_range(0, 99) < 45);
            accum_en   = ($urandom_range(0, 99) < 45);
            wr_addr    = AW'($urandom_range(0, 7));
            rd_addr    = AW'($urandom_range(0, 7));
            wr_mask    = NB'($urandom);
            rd_mask    = NB'($urandom);
            wr_zone_id = ($urandom_range(0, 9) == 0) ? ZW'(ZID + 1) : ZW'(ZID);
            rd_zone_id = ($urandom_range(0, 9) == 0) ? ZW'(ZID + 2) : ZW'(ZID);
            for (int b = 0; b < NB; b++)
                wdata[b*DW +: DW] = ($urandom_range(0, 3) == 0)
                                  ? {32'hFFFF_FFFF, $urandom}
                                  : {$urandom, $urandom};
            tick();
        end
        idle_in();
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
